// File: rtl/reorder_buffer.sv
// ---------------------------------------------------------------------------
// reorder_buffer
//
// Circular in-order reorder buffer for the out-of-order RV32I core.
// Entries are allocated at the tail on dispatch, completed out of order by
// ROB index on writeback, and retired in order from the head, one per cycle.
// The retired entry is presented on registered commit_* outputs for one cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   flush               discard every entry this cycle (beats all other ops)
//   dispatch_valid      instruction offered for allocation
//   dispatch_rd_addr    architectural destination (0 = no register write)
//   dispatch_ready      buffer not full; dispatch accepted iff valid && ready
//   alloc_rob_idx       index that the current dispatch receives
//   wb_valid/_rob_idx/_data   execution result for one entry
//   srcN_rob_idx        operand lookup index (N = 1, 2)
//   srcN_ready/_data    looked-up entry done (with writeback bypass) and value
//   commit_valid        an entry retired on the previous edge
//   commit_regf_we      commit_valid with a non-zero destination
//   commit_rd_addr/_data/_rob_idx   contents of the last retired entry
//   count               occupied entries, 0..ROB_DEPTH
// ---------------------------------------------------------------------------
module reorder_buffer #(
    parameter int ROB_DEPTH     = 32,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,

    input  logic                     dispatch_valid,
    input  logic [4:0]               dispatch_rd_addr,
    output logic                     dispatch_ready,
    output logic [ROB_IDX_WIDTH-1:0] alloc_rob_idx,

    input  logic                     wb_valid,
    input  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx,
    input  logic [31:0]              wb_data,

    input  logic [ROB_IDX_WIDTH-1:0] src1_rob_idx,
    input  logic [ROB_IDX_WIDTH-1:0] src2_rob_idx,
    output logic                     src1_ready,
    output logic                     src2_ready,
    output logic [31:0]              src1_data,
    output logic [31:0]              src2_data,

    output logic                     commit_valid,
    output logic                     commit_regf_we,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,

    output logic [ROB_IDX_WIDTH:0]   count
);

    localparam int PTR_W = ROB_IDX_WIDTH + 1;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    logic [PTR_W-1:0]         head_q, head_d;
    logic [PTR_W-1:0]         tail_q, tail_d;
    logic [ROB_IDX_WIDTH-1:0] head_idx, tail_idx;

    // Per-entry state.
    logic [ROB_DEPTH-1:0]     valid_q, valid_d;
    logic [ROB_DEPTH-1:0]     done_q, done_d;
    logic [4:0]               rd_q   [ROB_DEPTH];
    logic [4:0]               rd_d   [ROB_DEPTH];
    logic [31:0]              data_q [ROB_DEPTH];
    logic [31:0]              data_d [ROB_DEPTH];

    // Commit port registers.
    logic                     commit_valid_q, commit_valid_d;
    logic [4:0]               commit_rd_q, commit_rd_d;
    logic [31:0]              commit_data_q, commit_data_d;
    logic [ROB_IDX_WIDTH-1:0] commit_idx_q, commit_idx_d;

    logic empty, full;
    logic alloc_fire, commit_fire, wb_hit;
    logic src1_byp, src2_byp;

    assign head_idx = head_q[ROB_IDX_WIDTH-1:0];
    assign tail_idx = tail_q[ROB_IDX_WIDTH-1:0];

    assign empty = (head_q == tail_q);
    assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);

    // Ready depends on current occupancy only: a slot freed by this cycle's
    // commit becomes allocatable on the next cycle.
    assign dispatch_ready = !full;
    assign alloc_rob_idx  = tail_idx;
    assign count          = tail_q - head_q;

    assign alloc_fire  = !flush && dispatch_valid && !full;
    // Retirement looks at registered done bits, so a writeback to the head
    // entry only marks it done; it retires on the following edge.
    assign commit_fire = !flush && !empty && valid_q[head_idx] && done_q[head_idx];
    assign wb_hit      = !flush && wb_valid && valid_q[wb_rob_idx];

    // -----------------------------------------------------------------------
    // Per-entry next state. Allocation and retirement never target the same
    // slot: allocation needs not-full, retirement needs not-empty, and with
    // head_idx == tail_idx one of the two must hold. Writeback only hits valid
    // entries, so it never collides with an allocation either.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < ROB_DEPTH; gi++) begin : entry_g
            logic alloc_here, retire_here, wb_here;

            assign alloc_here  = alloc_fire  && (tail_idx   == ROB_IDX_WIDTH'(gi));
            assign retire_here = commit_fire && (head_idx   == ROB_IDX_WIDTH'(gi));
            assign wb_here     = wb_hit      && (wb_rob_idx == ROB_IDX_WIDTH'(gi));

            assign valid_d[gi] = flush       ? 1'b0 :
                                 alloc_here  ? 1'b1 :
                                 retire_here ? 1'b0 :
                                               valid_q[gi];

            assign done_d[gi]  = flush       ? 1'b0 :
                                 alloc_here  ? 1'b0 :
                                 retire_here ? 1'b0 :
                                 wb_here     ? 1'b1 :
                                               done_q[gi];

            assign rd_d[gi]    = alloc_here ? dispatch_rd_addr : rd_q[gi];
            assign data_d[gi]  = wb_here    ? wb_data          : data_q[gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Pointer and commit port next state.
    // -----------------------------------------------------------------------
    always_comb begin
        head_d         = head_q;
        tail_d         = tail_q;
        commit_valid_d = 1'b0;
        commit_rd_d    = commit_rd_q;
        commit_data_d  = commit_data_q;
        commit_idx_d   = commit_idx_q;

        if (flush) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_fire) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (commit_fire) begin
                head_d         = head_q + PTR_W'(1);
                commit_valid_d = 1'b1;
                commit_rd_d    = rd_q[head_idx];
                commit_data_d  = data_q[head_idx];
                commit_idx_d   = head_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q         <= '0;
            tail_q         <= '0;
            valid_q        <= '0;
            done_q         <= '0;
            commit_valid_q <= 1'b0;
            commit_rd_q    <= '0;
            commit_data_q  <= '0;
            commit_idx_q   <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            valid_q        <= valid_d;
            done_q         <= done_d;
            commit_valid_q <= commit_valid_d;
            commit_rd_q    <= commit_rd_d;
            commit_data_q  <= commit_data_d;
            commit_idx_q   <= commit_idx_d;
        end
    end

    // Payload storage is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        rd_q   <= rd_d;
        data_q <= data_d;
    end

    // -----------------------------------------------------------------------
    // Operand lookup with same-cycle writeback bypass.
    // -----------------------------------------------------------------------
    assign src1_byp   = wb_valid && (wb_rob_idx == src1_rob_idx) && valid_q[src1_rob_idx];
    assign src2_byp   = wb_valid && (wb_rob_idx == src2_rob_idx) && valid_q[src2_rob_idx];

    assign src1_ready = src1_byp || (valid_q[src1_rob_idx] && done_q[src1_rob_idx]);
    assign src2_ready = src2_byp || (valid_q[src2_rob_idx] && done_q[src2_rob_idx]);
    assign src1_data  = src1_byp ? wb_data : data_q[src1_rob_idx];
    assign src2_data  = src2_byp ? wb_data : data_q[src2_rob_idx];

    // -----------------------------------------------------------------------
    // Commit port.
    // -----------------------------------------------------------------------
    assign commit_valid   = commit_valid_q;
    assign commit_regf_we = commit_valid_q && (commit_rd_q != 5'd0);
    assign commit_rd_addr = commit_rd_q;
    assign commit_data    = commit_data_q;
    assign commit_rob_idx = commit_idx_q;

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        dispatch_valid;
    logic [4:0]  dispatch_rd_addr;
    logic        dispatch_ready;
    logic [4:0]  alloc_rob_idx;
    logic        wb_valid;
    logic [4:0]  wb_rob_idx;
    logic [31:0] wb_data;
    logic [4:0]  src1_rob_idx;
    logic [4:0]  src2_rob_idx;
    logic        src1_ready;
    logic        src2_ready;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    logic        commit_valid;
    logic        commit_regf_we;
    logic [4:0]  commit_rd_addr;
    logic [31:0] commit_data;
    logic [4:0]  commit_rob_idx;
    logic [5:0]  count;

    reorder_buffer #(.ROB_DEPTH(32), .ROB_IDX_WIDTH(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .dispatch_valid   (dispatch_valid),
        .dispatch_rd_addr (dispatch_rd_addr),
        .dispatch_ready   (dispatch_ready),
        .alloc_rob_idx    (alloc_rob_idx),
        .wb_valid         (wb_valid),
        .wb_rob_idx       (wb_rob_idx),
        .wb_data          (wb_data),
        .src1_rob_idx     (src1_rob_idx),
        .src2_rob_idx     (src2_rob_idx),
        .src1_ready       (src1_ready),
        .src2_ready       (src2_ready),
        .src1_data        (src1_data),
        .src2_data        (src2_data),
        .commit_valid     (commit_valid),
        .commit_regf_we   (commit_regf_we),
        .commit_rd_addr   (commit_rd_addr),
        .commit_data      (commit_data),
        .commit_rob_idx   (commit_rob_idx),
        .count            (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: one record per accepted dispatch, in program order.
    typedef struct {
        logic [4:0] idx;
        logic [4:0] rd;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] exp_data [32];
    int          exp_tail;
    int          n_checks;
    int          n_bad;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want)
        else begin
            n_bad++;
            $error("FAIL %s got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Every retirement is matched against the oldest outstanding dispatch.
    exp_t mon_e;
    always @(negedge clk) begin
        if (commit_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("commit_none_pending", {31'd0, commit_valid}, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("commit_rob_idx", {27'd0, commit_rob_idx}, {27'd0, mon_e.idx});
                check("commit_rd_addr", {27'd0, commit_rd_addr}, {27'd0, mon_e.rd});
                check("commit_data", commit_data, exp_data[mon_e.idx]);
                check("commit_regf_we", {31'd0, commit_regf_we}, {31'd0, (mon_e.rd != 5'd0)});
                $display("commit idx=%0d rd=%0d data=0x%08h we=%0b",
                         commit_rob_idx, commit_rd_addr, commit_data, commit_regf_we);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        flush            = 1'b0;
        dispatch_valid   = 1'b0;
        dispatch_rd_addr = 5'd0;
        wb_valid         = 1'b0;
        wb_rob_idx       = 5'd0;
        wb_data          = 32'd0;
        src1_rob_idx     = 5'd0;
        src2_rob_idx     = 5'd0;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_tail = 0;
        #1;
        check("rst_count", {26'd0, count}, 32'd0);
        check("rst_dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
        check("rst_alloc_idx", {27'd0, alloc_rob_idx}, 32'd0);
        check("rst_commit_valid", {31'd0, commit_valid}, 32'd0);
        check("rst_commit_we", {31'd0, commit_regf_we}, 32'd0);
        check("rst_commit_rd", {27'd0, commit_rd_addr}, 32'd0);
        check("rst_commit_data", commit_data, 32'd0);
        check("rst_commit_idx", {27'd0, commit_rob_idx}, 32'd0);
        $display("reset done");
    endtask

    task automatic dispatch(input logic [4:0] rd);
        exp_t e;
        check("dispatch_ready", {31'd0, dispatch_ready}, 32'd1);
        check("alloc_idx", {27'd0, alloc_rob_idx}, exp_tail);
        e.idx = 5'(exp_tail);
        e.rd  = rd;
        exp_q.push_back(e);
        dispatch_valid   = 1'b1;
        dispatch_rd_addr = rd;
        $display("dispatch idx=%0d rd=%0d", exp_tail, rd);
        exp_tail = (exp_tail + 1) % 32;
        tick();
        dispatch_valid = 1'b0;
    endtask

    task automatic writeback(input logic [4:0] idx, input logic [31:0] data);
        exp_data[idx] = data;
        wb_valid   = 1'b1;
        wb_rob_idx = idx;
        wb_data    = data;
        $display("writeback idx=%0d data=0x%08h", idx, data);
        tick();
        wb_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_bad    = 0;
        rst      = 1'b1;

        // ---------------- basic flow ----------------
        do_reset();
        dispatch(5'd5);
        check("basic_count_1", {26'd0, count}, 32'd1);
        writeback(5'd0, 32'hDEADBEEF);
        check("basic_no_commit_yet", {31'd0, commit_valid}, 32'd0);
        tick();
        check("basic_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("basic_commit_we", {31'd0, commit_regf_we}, 32'd1);
        check("basic_commit_rd", {27'd0, commit_rd_addr}, 32'd5);
        check("basic_commit_data", commit_data, 32'hDEADBEEF);
        check("basic_commit_idx", {27'd0, commit_rob_idx}, 32'd0);
        check("basic_count_0", {26'd0, count}, 32'd0);
        tick();
        check("basic_pulse_one_cycle", {31'd0, commit_valid}, 32'd0);
        check("basic_data_held", commit_data, 32'hDEADBEEF);

        // ---------------- out-of-order completion ----------------
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        dispatch(5'd3);
        writeback(5'd2, 32'h0000_0022);
        check("ooo_no_commit_a", {31'd0, commit_valid}, 32'd0);
        writeback(5'd1, 32'h0000_0011);
        check("ooo_no_commit_b", {31'd0, commit_valid}, 32'd0);
        writeback(5'd0, 32'h0000_00AA);
        check("ooo_no_commit_c", {31'd0, commit_valid}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("ooo_commit_valid", {31'd0, commit_valid}, 32'd1);
            check("ooo_commit_idx", {27'd0, commit_rob_idx}, k);
        end
        check("ooo_count_0", {26'd0, count}, 32'd0);
        tick();
        check("ooo_done", {31'd0, commit_valid}, 32'd0);

        // ---------------- full and wrap ----------------
        do_reset();
        for (int k = 0; k < 32; k++) begin
            dispatch(5'((k % 31) + 1));
        end
        check("full_count", {26'd0, count}, 32'd32);
        check("full_not_ready", {31'd0, dispatch_ready}, 32'd0);
        dispatch_valid   = 1'b1;
        dispatch_rd_addr = 5'd9;
        tick();
        dispatch_valid = 1'b0;
        check("full_reject_count", {26'd0, count}, 32'd32);
        check("full_reject_tail", {27'd0, alloc_rob_idx}, 32'd0);
        writeback(5'd0, 32'h0000_00A0);
        check("full_head_done_count", {26'd0, count}, 32'd32);
        check("full_head_done_not_ready", {31'd0, dispatch_ready}, 32'd0);
        tick();
        check("full_after_commit_count", {26'd0, count}, 32'd31);
        check("full_after_commit_ready", {31'd0, dispatch_ready}, 32'd1);
        check("full_after_commit_valid", {31'd0, commit_valid}, 32'd1);
        dispatch(5'd7);
        check("wrap_refull_ready", {31'd0, dispatch_ready}, 32'd0);
        writeback(5'd1, 32'h0000_00A1);
        tick();
        check("wrap_next_alloc_idx", {27'd0, alloc_rob_idx}, 32'd1);
        dispatch(5'd8);
        for (int k = 31; k >= 2; k--) begin
            writeback(5'(k), 32'h0000_0B00 + 32'(k));
        end
        writeback(5'd1, 32'h0000_0C01);
        writeback(5'd0, 32'h0000_0C00);
        for (int k = 0; k < 64 && count != 6'd0; k++) begin
            tick();
        end
        check("wrap_drained_count", {26'd0, count}, 32'd0);
        tick();
        check("wrap_all_committed", 32'(exp_q.size()), 32'd0);

        // ---------------- rd = 0 ----------------
        do_reset();
        dispatch(5'd0);
        writeback(5'd0, 32'h0000_1234);
        tick();
        check("rd0_commit_valid", {31'd0, commit_valid}, 32'd1);
        check("rd0_commit_we", {31'd0, commit_regf_we}, 32'd0);
        check("rd0_commit_data", commit_data, 32'h0000_1234);

        // ---------------- bypass, stray writeback, flush ----------------
        do_reset();
        dispatch(5'd1);
        dispatch(5'd2);
        dispatch(5'd3);
        dispatch(5'd4);
        src1_rob_idx = 5'd3;
        #1;
        check("byp_not_ready", {31'd0, src1_ready}, 32'd0);
        exp_data[3] = 32'h0000_0055;
        wb_valid   = 1'b1;
        wb_rob_idx = 5'd3;
        wb_data    = 32'h0000_0055;
        #1;
        check("byp_ready", {31'd0, src1_ready}, 32'd1);
        check("byp_data", src1_data, 32'h0000_0055);
        tick();
        wb_valid = 1'b0;
        #1;
        check("byp_stored_ready", {31'd0, src1_ready}, 32'd1);
        check("byp_stored_data", src1_data, 32'h0000_0055);
        $display("bypass idx=3 ready=%0b data=0x%08h", src1_ready, src1_data);

        src2_rob_idx = 5'd10;
        wb_valid   = 1'b1;
        wb_rob_idx = 5'd10;
        wb_data    = 32'h0000_0099;
        #1;
        check("stray_no_bypass", {31'd0, src2_ready}, 32'd0);
        tick();
        wb_valid = 1'b0;
        #1;
        check("stray_not_done", {31'd0, src2_ready}, 32'd0);
        check("stray_count", {26'd0, count}, 32'd4);
        check("stray_tail", {27'd0, alloc_rob_idx}, 32'd4);

        writeback(5'd2, 32'h0000_0022);
        check("flush_pre_no_commit", {31'd0, commit_valid}, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        exp_tail = 0;
        #1;
        check("flush_count", {26'd0, count}, 32'd0);
        check("flush_commit_valid", {31'd0, commit_valid}, 32'd0);
        check("flush_alloc_idx", {27'd0, alloc_rob_idx}, 32'd0);
        check("flush_ready", {31'd0, dispatch_ready}, 32'd1);
        check("flush_done_cleared", {31'd0, src1_ready}, 32'd0);
        $display("flush count=%0d", count);
        repeat (4) tick();
        check("flush_no_late_commit", {31'd0, commit_valid}, 32'd0);
        dispatch(5'd6);
        writeback(5'd0, 32'h0000_0066);
        tick();
        check("post_flush_commit", {31'd0, commit_valid}, 32'd1);
        check("post_flush_idx", {27'd0, commit_rob_idx}, 32'd0);
        tick();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular in-order reorder buffer for the out-of-order RV32I core. Allocates one entry per dispatched instruction and returns its ROB index for renaming. Captures execution results by ROB index. Retires completed head entries one per cycle onto the commit port consumed by the rename/architectural register file; that port writes architectural data and clears the rename ready state.

## Interface
- ROB_DEPTH, 32, number of entries; power of two.
- ROB_IDX_WIDTH, 5, log2(ROB_DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries this cycle.
- dispatch_valid  in  1  instruction presented for allocation.
- dispatch_rd_addr  in  5  architectural destination; 0 means no register write.
- dispatch_ready  out  1  buffer not full; allocation accepted this cycle iff dispatch_valid && dispatch_ready.
- alloc_rob_idx  out  ROB_IDX_WIDTH  index the current dispatch receives (tail).
- wb_valid  in  1  execution result valid.
- wb_rob_idx  in  ROB_IDX_WIDTH  entry being completed.
- wb_data  in  32  result value.
- src1_rob_idx, src2_rob_idx  in  ROB_IDX_WIDTH  operand lookup indices.
- src1_ready, src2_ready  out  1  looked-up entry valid and done.
- src1_data, src2_data  out  32  looked-up entry data.
- commit_valid  out  1  an entry retired last cycle.
- commit_regf_we  out  1  commit_valid && commit_rd_addr != 0.
- commit_rd_addr  out  5  retired destination.
- commit_data  out  32  retired value.
- commit_rob_idx  out  ROB_IDX_WIDTH  retired index.
- count  out  ROB_IDX_WIDTH+1  occupied entries, 0..ROB_DEPTH.

## Operation
- Per-entry state: valid, done, rd_addr[4:0], data[31:0].
- head and tail pointers are ROB_IDX_WIDTH+1 bits; low bits index the array and the MSB is the wrap bit.
- Empty when head == tail. Full when the index bits are equal and the wrap bits differ.
- Dispatch: on an accepted dispatch, entry[tail] gets valid=1, done=0, rd_addr=dispatch_rd_addr, and tail increments (wraps naturally).
- dispatch_ready = !full. It is computed from current state only, so a slot freed by a same-cycle commit is not reusable until the next cycle.
- Writeback: if wb_valid and entry[wb_rob_idx].valid, set done=1 and data=wb_data. Writeback to an invalid entry is ignored.
- Commit: if not empty and entry[head] has valid && done, the entry retires at the clock edge:
  - valid clears and head increments;
  - commit_* registers load the entry contents and commit_valid=1 for exactly one cycle.
  - Otherwise commit_valid=0 next cycle, and commit_rd_addr/commit_data/commit_rob_idx hold their last values.
- Lookup (combinational): srcN_ready = entry.valid && entry.done, srcN_data = entry.data.
  - Bypass: if wb_valid && wb_rob_idx == srcN_rob_idx && entry valid, then srcN_ready=1 and srcN_data=wb_data.
- Dispatch, writeback and commit can all occur in the same cycle, including writeback to the head entry. Head writeback only sets done; it does not commit that cycle.
- count = tail − head, (ROB_IDX_WIDTH+1)-bit modular.
- Flush has priority over dispatch, writeback and commit:
  - all valid and done bits clear, head = tail = 0;
  - commit_valid=0 the following cycle; nothing is retired in the flush cycle.

## Timing
- Reset values: all entries invalid, head=tail=0, dispatch_ready=1, alloc_rob_idx=0, count=0, commit_valid=0, commit_regf_we=0, commit_rd_addr=0, commit_data=0, commit_rob_idx=0.
- Reset asserted mid-operation behaves identically to flush, and additionally zeroes the commit_* registers.
- Allocation latency: alloc_rob_idx is valid in the same cycle as dispatch_valid; the entry is occupied from the next edge.
- Writeback in cycle N to the head entry produces a commit at edge N+1, with commit_valid high during cycle N+2.
- Back-to-back completed entries commit one per cycle, with no bubbles.
- When full with the head done, the head commits, dispatch_ready rises the next cycle, and count drops by 1.
- Pointer wrap: after index ROB_DEPTH−1, alloc_rob_idx returns to 0 and the wrap bit toggles. Ordering is preserved across the wrap.

## Test plan
- **Basic flow:** after reset, dispatch rd=5 (idx 0), writeback idx0 data 0xDEADBEEF → two cycles later commit_valid=1, commit_regf_we=1, commit_rd_addr=5, commit_data=0xDEADBEEF, commit_rob_idx=0; count returns to 0.
- **Out-of-order completion:** dispatch rd=1,2,3 (idx 0,1,2), writeback in order 2,1,0 → commits on three consecutive cycles in order idx 0,1,2; commit_valid is never high before idx0's writeback.
- **Full/wrap:**
  - dispatch 32 with no writeback → count=32, dispatch_ready=0; a further dispatch_valid is not allocated.
  - Complete idx0 → commit, then dispatch_ready=1 and alloc_rob_idx=0; next alloc after that is idx1.
- **rd=0:** dispatch rd=0, writeback 0x1234 → commit_valid=1 and commit_regf_we=0.
- **Bypass and stray writeback:**
  - src1_rob_idx=3 (valid, not done) with wb_valid idx3 data 0x55 same cycle → src1_ready=1, src1_data=0x55.
  - Writeback to an invalid idx 10 → no state change.
- **Flush:** with 4 entries, 2 done, assert flush → next cycle count=0, commit_valid=0, alloc_rob_idx=0; no commits follow.
